// File: rtl/current_fir_sequencer.sv
// Frame sequencer for current_fir_filter: packs serially arriving channel samples
// into one vector, runs the filter in/out handshakes and flags overruns / lost frames.
module current_fir_sequencer #(
  parameter  int DATA_WIDTH = 16,
  parameter  int DATA_COUNT = 3,
  parameter  int TIMEOUT    = 255,
  localparam int CH_WIDTH   = (DATA_COUNT > 1) ? $clog2(DATA_COUNT) : 1,
  localparam int VW         = DATA_WIDTH * DATA_COUNT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                frame_start,
  input  logic [DATA_WIDTH-1:0] sample_data,
  input  logic [CH_WIDTH-1:0] sample_channel,
  input  logic                sample_valid,
  output logic [VW-1:0]       fir_in_data,
  output logic                fir_in_valid,
  input  logic                fir_in_ready,
  input  logic [VW-1:0]       fir_out_data,
  input  logic                fir_out_valid,
  output logic                fir_out_ready,
  output logic [VW-1:0]       result_data,
  output logic                result_valid,
  output logic                overrun,
  output logic                incomplete,
  input  logic                clear_errors
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WAIT_RESULT} state_e;

  state_e                                state_q, state_d;
  logic [DATA_COUNT-1:0]                 mask_q, mask_d;
  logic [CNT_W-1:0]                      cnt_q, cnt_d;
  // Packed slots: element DATA_COUNT-1-k holds channel k, so channel 0 lands in the MSBs.
  logic [DATA_COUNT-1:0][DATA_WIDTH-1:0] slot_q, slot_d;
  logic [VW-1:0]                         result_q, result_d;
  logic                                  in_valid_q, in_valid_d;
  logic                                  out_ready_q, out_ready_d;
  logic                                  res_vld_q, res_vld_d;
  logic                                  ovr_q, ovr_d, inc_q, inc_d;
  logic [DATA_COUNT-1:0]                 hit;
  logic                                  accept, ovr_set, inc_set;

  always_comb begin
    hit = '0;
    for (int k = 0; k < DATA_COUNT; k++)
      if (sample_valid && int'(sample_channel) == k) hit[k] = 1'b1;

    state_d   = state_q;
    mask_d    = mask_q;
    cnt_d     = cnt_q;
    slot_d    = slot_q;
    result_d  = result_q;
    res_vld_d = 1'b0;
    ovr_set   = 1'b0;
    inc_set   = 1'b0;
    accept    = 1'b0;

    case (state_q)
      IDLE: begin
        if (frame_start) begin
          accept  = 1'b1;
          mask_d  = hit;
          cnt_d   = '0;
          state_d = (&hit) ? ISSUE : COLLECT;
        end
      end
      COLLECT: begin
        accept  = 1'b1;
        mask_d  = (frame_start ? '0 : mask_q) | hit;
        cnt_d   = frame_start ? '0 : cnt_q + 1'b1;
        inc_set = frame_start;
        // A completing sample beats the timeout on the same cycle.
        if (&mask_d) begin
          state_d = ISSUE;
        end else if (!frame_start && cnt_d == CNT_W'(TIMEOUT)) begin
          state_d = IDLE;
          inc_set = 1'b1;
        end
      end
      ISSUE: begin
        ovr_set = sample_valid | frame_start;
        if (in_valid_q && fir_in_ready) state_d = WAIT_RESULT;
      end
      WAIT_RESULT: begin
        ovr_set = sample_valid | frame_start;
        if (fir_out_valid) begin
          result_d  = fir_out_data;
          res_vld_d = 1'b1;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (accept)
      for (int k = 0; k < DATA_COUNT; k++)
        if (hit[k]) slot_d[DATA_COUNT-1-k] = sample_data;

    in_valid_d  = (state_d == ISSUE);
    out_ready_d = (state_d == WAIT_RESULT);
    ovr_d       = ovr_set | (ovr_q & ~clear_errors);
    inc_d       = inc_set | (inc_q & ~clear_errors);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      cnt_q       <= '0;
      slot_q      <= '0;
      result_q    <= '0;
      in_valid_q  <= 1'b0;
      out_ready_q <= 1'b0;
      res_vld_q   <= 1'b0;
      ovr_q       <= 1'b0;
      inc_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      result_q    <= result_d;
      in_valid_q  <= in_valid_d;
      out_ready_q <= out_ready_d;
      res_vld_q   <= res_vld_d;
      ovr_q       <= ovr_d;
      inc_q       <= inc_d;
    end
  end

  assign fir_in_data   = slot_q;
  assign fir_in_valid  = in_valid_q;
  assign fir_out_ready = out_ready_q;
  assign result_data   = result_q;
  assign result_valid  = res_vld_q;
  assign overrun       = ovr_q;
  assign incomplete    = inc_q;

endmodule

// File: tb/tb_current_fir_sequencer.sv
// Bench for current_fir_sequencer: directed scenarios plus randomized frames checked
// against a per-channel array model of the frame and the flag rules.
module tb_current_fir_sequencer;
  localparam int DW = 16, DC = 2, TO = 8, VW = DW * DC, CHW = 1;

  logic clk = 1'b0, reset = 1'b0;
  logic frame_start = 1'b0, sample_valid = 1'b0, clear_errors = 1'b0;
  logic fir_in_ready = 1'b0, fir_out_valid = 1'b0;
  logic [DW-1:0]  sample_data = '0;
  logic [CHW-1:0] sample_channel = '0;
  logic [VW-1:0]  fir_out_data = '0;
  logic [VW-1:0]  fir_in_data, result_data;
  logic fir_in_valid, fir_out_ready, result_valid, overrun, incomplete;

  int n_chk = 0, n_pass = 0;
  logic [DW-1:0] slot [DC];
  logic [DC-1:0] mask;
  logic exp_ovr = 1'b0, exp_inc = 1'b0;
  logic [VW-1:0] last_res = '0;

  current_fir_sequencer #(.DATA_WIDTH(DW), .DATA_COUNT(DC), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .frame_start(frame_start), .sample_data(sample_data),
    .sample_channel(sample_channel), .sample_valid(sample_valid),
    .fir_in_data(fir_in_data), .fir_in_valid(fir_in_valid), .fir_in_ready(fir_in_ready),
    .fir_out_data(fir_out_data), .fir_out_valid(fir_out_valid), .fir_out_ready(fir_out_ready),
    .result_data(result_data), .result_valid(result_valid), .overrun(overrun),
    .incomplete(incomplete), .clear_errors(clear_errors));

  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One clock with the given sample-side inputs; the model is updated alongside.
  task automatic step(input logic fs, input logic v, input int ch, input logic [DW-1:0] d);
    frame_start = fs; sample_valid = v; sample_channel = CHW'(ch); sample_data = d;
    tick();
    frame_start = 1'b0; sample_valid = 1'b0;
  endtask

  function automatic logic [VW-1:0] exp_frame();
    logic [VW-1:0] f;
    for (int k = 0; k < DC; k++) f[VW-1-DW*k -: DW] = slot[k];
    return f;
  endfunction

  task automatic model_sample(input logic v, input int ch, input logic [DW-1:0] d);
    if (v && ch < DC) begin slot[ch] = d; mask[ch] = 1'b1; end
  endtask

  task automatic clear_flags();
    clear_errors = 1'b1; step(0, 0, 0, '0); clear_errors = 1'b0;
    exp_ovr = 1'b0; exp_inc = 1'b0;
    chk("clr_ovr", {63'd0, overrun}, 64'd0);
    chk("clr_inc", {63'd0, incomplete}, 64'd0);
  endtask

  // Stall random/fixed cycles on each side of the filter, optionally injecting dropped samples.
  task automatic finish_frame(input int in_stall, input int out_stall, input bit inject);
    logic [VW-1:0] f;
    f = exp_frame();
    chk("in_valid", {63'd0, fir_in_valid}, 64'd1);
    chk("in_data", {32'd0, fir_in_data}, {32'd0, f});
    for (int i = 0; i < in_stall; i++) begin
      if (inject && $urandom_range(0, 2) == 0) begin
        step(1'($urandom_range(0, 1)), 1, $urandom_range(0, 1), DW'($urandom)); exp_ovr = 1'b1;
      end else step(0, 0, 0, '0);
      chk("in_hold_v", {63'd0, fir_in_valid}, 64'd1);
      chk("in_hold_d", {32'd0, fir_in_data}, {32'd0, f});
      chk("no_oready", {63'd0, fir_out_ready}, 64'd0);
    end
    fir_in_ready = 1'b1; step(0, 0, 0, '0); fir_in_ready = 1'b0;
    chk("oready_up", {63'd0, fir_out_ready}, 64'd1);
    chk("ivalid_dn", {63'd0, fir_in_valid}, 64'd0);
    for (int i = 0; i < out_stall; i++) begin
      if (inject && $urandom_range(0, 2) == 0) begin
        step(0, 1, $urandom_range(0, 1), DW'($urandom)); exp_ovr = 1'b1;
      end else step(0, 0, 0, '0);
      chk("oready_hold", {63'd0, fir_out_ready}, 64'd1);
      chk("no_result", {63'd0, result_valid}, 64'd0);
    end
    fir_out_data = VW'($urandom); fir_out_valid = 1'b1; step(0, 0, 0, '0); fir_out_valid = 1'b0;
    last_res = fir_out_data;
    chk("res_valid", {63'd0, result_valid}, 64'd1);
    chk("res_data", {32'd0, result_data}, {32'd0, last_res});
    chk("oready_dn", {63'd0, fir_out_ready}, 64'd0);
    fir_out_data = VW'($urandom);
    step(0, 0, 0, '0);
    chk("res_pulse", {63'd0, result_valid}, 64'd0);
    chk("res_hold", {32'd0, result_data}, {32'd0, last_res});
    chk("ovr_flag", {63'd0, overrun}, {63'd0, exp_ovr});
    chk("inc_flag", {63'd0, incomplete}, {63'd0, exp_inc});
  endtask

  initial begin
    int cyc;
    bit done;
    logic fs, v;
    int ch;
    logic [DW-1:0] d;

    // Reset state
    repeat (2) tick();
    chk("rst_ivalid", {63'd0, fir_in_valid}, 64'd0);
    chk("rst_oready", {63'd0, fir_out_ready}, 64'd0);
    chk("rst_rvalid", {63'd0, result_valid}, 64'd0);
    chk("rst_ovr", {63'd0, overrun}, 64'd0);
    chk("rst_inc", {63'd0, incomplete}, 64'd0);
    chk("rst_idata", {32'd0, fir_in_data}, 64'd0);
    chk("rst_rdata", {32'd0, result_data}, 64'd0);
    @(negedge clk) reset = 1'b1;

    // Basic frame: ch0=1000, ch1=-1000
    mask = '0;
    step(1, 0, 0, '0);
    step(0, 1, 0, 16'd1000);  model_sample(1, 0, 16'd1000);
    chk("t1_not_yet", {63'd0, fir_in_valid}, 64'd0);
    step(0, 1, 1, 16'hFC18);  model_sample(1, 1, 16'hFC18);
    chk("t1_frame", {32'd0, fir_in_data}, 64'h03E8FC18);
    finish_frame(0, 0, 0);

    // Backpressure on both sides
    mask = '0;
    step(1, 1, 1, 16'h1234);  model_sample(1, 1, 16'h1234);
    step(0, 1, 0, 16'hBEEF);  model_sample(1, 0, 16'hBEEF);
    finish_frame(20, 15, 0);

    // Overrun during ISSUE; set beats a simultaneous clear
    mask = '0;
    step(1, 0, 0, '0);
    step(0, 1, 0, 16'd11);    model_sample(1, 0, 16'd11);
    step(0, 1, 1, 16'd5);     model_sample(1, 1, 16'd5);
    clear_errors = 1'b1; step(0, 1, 0, 16'd99); clear_errors = 1'b0; exp_ovr = 1'b1;
    chk("t3_ovr_set", {63'd0, overrun}, 64'd1);
    finish_frame(2, 2, 0);
    step(0, 0, 0, '0);
    chk("t3_ovr_sticky", {63'd0, overrun}, 64'd1);
    clear_flags();

    // Timeout with only ch0
    step(1, 0, 0, '0);
    step(0, 1, 0, 16'd7);
    repeat (6) begin
      step(0, 0, 0, '0);
      chk("t4_inc_early", {63'd0, incomplete}, 64'd0);
    end
    step(0, 0, 0, '0);
    chk("t4_inc", {63'd0, incomplete}, 64'd1);
    chk("t4_no_valid", {63'd0, fir_in_valid}, 64'd0);
    step(0, 1, 1, 16'd5);
    chk("t4_idle_ignore", {63'd0, fir_in_valid}, 64'd0);
    clear_flags();

    // Restart mid-frame with a same-cycle sample
    mask = '0;
    step(1, 0, 0, '0);
    step(0, 1, 0, 16'd7);
    step(1, 1, 1, 16'd9);
    step(0, 1, 0, 16'd3);
    slot[0] = 16'd3; slot[1] = 16'd9; exp_inc = 1'b1;
    chk("t5_inc", {63'd0, incomplete}, 64'd1);
    chk("t5_frame", {32'd0, fir_in_data}, 64'h00030009);
    finish_frame(1, 1, 0);
    clear_flags();

    // Asynchronous reset during WAIT_RESULT
    step(1, 1, 0, 16'hAAAA);
    step(0, 1, 1, 16'h5555);
    fir_in_ready = 1'b1; step(0, 0, 0, '0); fir_in_ready = 1'b0;
    chk("t6_wait", {63'd0, fir_out_ready}, 64'd1);
    #2 reset = 1'b0; #1;
    chk("t6_oready", {63'd0, fir_out_ready}, 64'd0);
    chk("t6_ivalid", {63'd0, fir_in_valid}, 64'd0);
    chk("t6_idata", {32'd0, fir_in_data}, 64'd0);
    chk("t6_rdata", {32'd0, result_data}, 64'd0);
    chk("t6_flags", {62'd0, overrun, incomplete}, 64'd0);
    @(negedge clk) reset = 1'b1;
    exp_ovr = 1'b0; exp_inc = 1'b0; mask = '0;
    step(1, 0, 0, '0);
    step(0, 1, 1, 16'h0F0F);  model_sample(1, 1, 16'h0F0F);
    step(0, 1, 0, 16'hF0F0);  model_sample(1, 0, 16'hF0F0);
    finish_frame(0, 0, 0);

    // Randomized frames: gaps, duplicates, restarts, timeouts, stalls and dropped samples
    for (int f = 0; f < 40; f++) begin
      mask = '0; cyc = 0; done = 1'b0;
      v = 1'($urandom_range(0, 1)); ch = $urandom_range(0, 1); d = DW'($urandom);
      step(1, v, ch, d); model_sample(v, ch, d);
      while (!done) begin
        if (&mask) begin
          finish_frame($urandom_range(0, 4), $urandom_range(0, 4), 1);
          done = 1'b1;
        end else if (cyc == TO) begin
          exp_inc = 1'b1;
          chk("r_abandon_v", {63'd0, fir_in_valid}, 64'd0);
          chk("r_abandon_i", {63'd0, incomplete}, 64'd1);
          step(0, 1, $urandom_range(0, 1), DW'($urandom));
          chk("r_idle_ign", {63'd0, fir_in_valid}, 64'd0);
          chk("r_idle_ovr", {63'd0, overrun}, {63'd0, exp_ovr});
          done = 1'b1;
        end else begin
          chk("r_collect", {63'd0, fir_in_valid}, 64'd0);
          fs = ($urandom_range(0, 15) == 0);
          v  = ($urandom_range(0, 9) < 4);
          ch = $urandom_range(0, 1); d = DW'($urandom);
          step(fs, v, ch, d);
          if (fs) begin mask = '0; cyc = 0; exp_inc = 1'b1; end
          else cyc++;
          model_sample(v, ch, d);
        end
      end
      if ($urandom_range(0, 2) == 0) clear_flags();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/current_fir_sequencer.md
# current_fir_sequencer

Frame sequencer in front of `current_fir_filter`. It collects per-channel ADC current samples that arrive serially with a channel index, and packs one frame into the filter's `DATA_COUNT`-wide input vector. It then drives the filter's valid/ready handshakes, captures the filtered vector and emits a single-cycle result strobe to the motor control logic. It also flags overruns and incomplete frames.

## Interface
Parameters:
- `DATA_WIDTH`, 16, width of one sample (two's complement).
- `DATA_COUNT`, 3, channels per frame; must be ≥1.
- `TIMEOUT`, 255, maximum clk cycles spent in COLLECT before the frame is abandoned; must be ≥1.
- `CH_WIDTH`, derived localparam, equals max(1, clog2(DATA_COUNT)).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-low reset.
- `frame_start`  in  1  single-cycle pulse that opens a new frame.
- `sample_data`  in  DATA_WIDTH  sample value.
- `sample_channel`  in  CH_WIDTH  channel index of the sample.
- `sample_valid`  in  1  sample strobe; there is no backpressure.
- `fir_in_data`  out  DATA_WIDTH*DATA_COUNT  packed frame; channel k occupies bits [DATA_WIDTH*(DATA_COUNT-k)-1 -: DATA_WIDTH], so channel 0 is in the MSBs.
- `fir_in_valid`  out  1  drives the filter's `in_valid`.
- `fir_in_ready`  in  1  from the filter's `in_ready`.
- `fir_out_data`  in  DATA_WIDTH*DATA_COUNT  filtered vector, same packing as `fir_in_data`.
- `fir_out_valid`  in  1  from the filter's `out_valid`.
- `fir_out_ready`  out  1  drives the filter's `out_ready`.
- `result_data`  out  DATA_WIDTH*DATA_COUNT  last filtered vector; holds its value until the next result.
- `result_valid`  out  1  one-cycle strobe marking a new `result_data`.
- `overrun`  out  1  sticky; a sample or frame_start arrived while the filter was busy.
- `incomplete`  out  1  sticky; a frame was abandoned because of timeout or restart.
- `clear_errors`  in  1  clears both sticky flags.

## Operation
- FSM states are IDLE, COLLECT, ISSUE and WAIT_RESULT. Reset enters IDLE.
- IDLE:
  - `frame_start` clears the received-channel mask and the timeout counter, then moves to COLLECT.
  - A `sample_valid` in the same cycle as `frame_start` is accepted into the new frame.
  - Samples arriving in IDLE without `frame_start` are ignored, with no flag.
- COLLECT:
  - Each `sample_valid` with `sample_channel` < DATA_COUNT writes that channel's slot and sets its mask bit.
  - A duplicate channel overwrites the slot without raising an error.
  - An index ≥ DATA_COUNT is ignored.
  - When the mask becomes all-ones (including on the accepting cycle), the next state is ISSUE.
  - The counter increments every cycle. On reaching TIMEOUT without a full mask, the frame is abandoned, the state returns to IDLE and `incomplete` is set.
  - A `frame_start` in COLLECT restarts the frame: mask and counter are cleared, the state stays COLLECT, and `incomplete` is set. A same-cycle sample belongs to the new frame.
- ISSUE:
  - `fir_in_valid`=1 with `fir_in_data` held stable until `fir_in_ready`.
  - On `fir_in_valid` & `fir_in_ready`, the next state is WAIT_RESULT.
- WAIT_RESULT:
  - `fir_out_ready`=1.
  - On `fir_out_valid`, `fir_out_data` is latched into `result_data`, `result_valid` pulses, and the next state is IDLE.
- In ISSUE or WAIT_RESULT, any `sample_valid` or `frame_start` is dropped and sets `overrun`. The state is unaffected.
- Sticky flags: a set condition wins over `clear_errors` in the same cycle. Otherwise `clear_errors` clears the flag on the next edge.
- No arithmetic is performed. Data passes through bit-exact.

## Timing
- Reset values:
  - `fir_in_valid`, `fir_out_ready`, `result_valid`, `overrun`, `incomplete` = 0.
  - `fir_in_data`, `result_data` = 0.
  - State is IDLE.
- Reset asserted mid-frame or mid-handshake returns to IDLE immediately; there is no replay.
- Latency through the block:
  - `frame_start` at edge t puts the FSM in COLLECT from t+1.
  - The last missing sample accepted at edge t gives `fir_in_valid`=1 from t+1.
  - A handshake at edge t gives `fir_out_ready`=1 from t+1.
  - `fir_out_valid` sampled at edge t gives `result_valid`=1 for exactly the cycle after t, and IDLE.
- `fir_in_valid` never deasserts before the handshake. `fir_out_ready` is high only in WAIT_RESULT.
- With DATA_COUNT=1, a single sample completes the frame.

## Test plan
- DATA_COUNT=2; frame_start, then ch0=1000 and ch1=-1000 on consecutive cycles; filter always ready. Required: `fir_in_data`=0x03E8_FC18 with `fir_in_valid` one cycle after the ch1 sample; `result_valid` exactly one cycle; `result_data` equals the filter output.
- Backpressure: `fir_in_ready` held low for 20 cycles, `fir_out_ready` path stalled by withholding `fir_out_valid` for 15 cycles. Required: `fir_in_valid` and `fir_in_data` stable throughout; exactly one result; no flags.
- Samples ch1=5 then a sample during ISSUE. Required: the ISSUE sample is dropped; `overrun`=1 persists until a `clear_errors` pulse and is 0 on the cycle after it.
- TIMEOUT=8; frame_start and only ch0 supplied. Required: IDLE after 8 cycles in COLLECT, `incomplete`=1, no `fir_in_valid`.
- frame_start, ch0=7, frame_start plus ch1=9 in the same cycle, then ch0=3. Required: `incomplete`=1 and the issued frame is {3, 9}.
- Assert reset during WAIT_RESULT. Required: all outputs 0 asynchronously; the next frame after release completes normally.
